// File: rtl/ni_tx_pkg.sv
// Shared widths, default buffer depth and FSM encoding for the network-interface
// transmit path.
package ni_tx_pkg;

  localparam int DATAW         = 31;  // flit is DATAW+1 bits
  localparam int VCH           = 3;   // highest VC index
  localparam int VCHW          = 1;   // VC index is VCHW+1 bits
  localparam int BUF_DEPTH_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/ni_credit.sv
// One virtual channel's credit counter; flags a credit returned while the
// counter is already full.
module ni_credit #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          send_i,
  input  logic          ack_i,
  output logic [CW-1:0] credit_o,
  output logic          err_o
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] credit_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      credit_q <= FULL;
      err_q    <= 1'b0;
    end else begin
      case ({send_i, ack_i})
        2'b10: credit_q <= credit_q - CW'(1);
        2'b01: begin
          // A surplus credit is dropped so the count never exceeds the buffer.
          if (credit_q == FULL) err_q <= 1'b1;
          else                  credit_q <= credit_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

endmodule

// File: rtl/ni_tx.sv
// Network-interface transmitter: allocates a free router VC round-robin per packet
// and streams flits onto it under per-VC credit flow control.
module ni_tx
  import ni_tx_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int NVC       = VCH + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_,
  input  logic [DATAW:0]                       src_data,
  input  logic                                 src_valid,
  input  logic                                 src_last,
  output logic                                 src_ready,
  output logic [DATAW:0]                       odata,
  output logic                                 ovalid,
  output logic [VCHW:0]                        ovch,
  input  logic [NVC-1:0]                       iack,
  input  logic [NVC-1:0]                       irdy,
  input  logic [NVC-1:0]                       ilck,
  output logic                                 busy,
  output logic                                 err,
  output state_e                               dbg_state,
  output logic [NVC*$clog2(BUF_DEPTH+1)-1:0]   dbg_credit
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int VW = VCHW + 1;

  // Handshake: a flit moves when src_valid && src_ready at a rising edge and
  // shows up on odata/ovch with ovalid=1 in the following cycle only.

  state_e         state_q;
  logic [VW-1:0]  cur_vc_q, rr_q, bar_vc_q;
  logic           bar_q;
  logic [DATAW:0] odata_q;
  logic           ovalid_q;
  logic [VW-1:0]  ovch_q;

  logic [CW-1:0]  credit [NVC];
  logic [NVC-1:0] send_v, err_v, elig;
  logic           accept, found;
  logic [VW-1:0]  pick;
  int             idx;

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    ni_credit #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_credit (
      .clk      (clk),
      .rst_     (rst_),
      .send_i   (send_v[v]),
      .ack_i    (iack[v]),
      .credit_o (credit[v]),
      .err_o    (err_v[v])
    );
    assign send_v[v]                = accept && (cur_vc_q == VW'(v));
    assign dbg_credit[v*CW +: CW]   = credit[v];
  end

  assign src_ready = (state_q == ST_SEND) && (credit[cur_vc_q] != '0);
  assign accept    = src_valid && src_ready;

  // A VC is only handed out once its router buffer has fully drained.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    for (int v = 0; v < NVC; v++) begin
      elig[v] = irdy[v] && !ilck[v] && (credit[v] == CW'(BUF_DEPTH)) &&
                !(bar_q && (bar_vc_q == VW'(v)));
    end
    for (int i = 1; i <= NVC; i++) begin
      idx = (int'(rr_q) + i) % NVC;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = VW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      cur_vc_q <= '0;
      rr_q     <= VW'(NVC - 1);
      bar_q    <= 1'b0;
      bar_vc_q <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      ovalid_q <= accept;
      bar_q    <= 1'b0;
      if (accept) begin
        odata_q <= src_data;
        ovch_q  <= cur_vc_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (src_valid && found) begin
            cur_vc_q <= pick;
            rr_q     <= pick;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept && src_last) begin
            state_q  <= ST_IDLE;
            bar_q    <= 1'b1;
            bar_vc_q <= cur_vc_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = |err_v;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ni_tx.sv
// Bench for ni_tx: directed scenarios plus random traffic, checked against a
// behavioural model of allocation, credits and flit forwarding.
module tb_ni_tx;
  import ni_tx_pkg::*;

  localparam int BD  = BUF_DEPTH_DEF;
  localparam int NVC = VCH + 1;
  localparam int CW  = $clog2(BD + 1);
  localparam int DW  = DATAW + 1;
  localparam int VW  = VCHW + 1;

  logic           clk = 1'b0;
  logic           rst_ = 1'b1;
  logic [DW-1:0]  src_data = '0;
  logic           src_valid = 1'b0;
  logic           src_last = 1'b0;
  logic           src_ready;
  logic [DW-1:0]  odata;
  logic           ovalid;
  logic [VW-1:0]  ovch;
  logic [NVC-1:0] iack = '0;
  logic [NVC-1:0] irdy = '1;
  logic [NVC-1:0] ilck = '0;
  logic           busy, err;
  state_e         dbg_state;
  logic [NVC*CW-1:0] dbg_credit;

  int checks = 0;
  int errors = 0;

  ni_tx #(.BUF_DEPTH(BD), .NVC(NVC)) dut (
    .clk(clk), .rst_(rst_), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .odata(odata), .ovalid(ovalid),
    .ovch(ovch), .iack(iack), .irdy(irdy), .ilck(ilck), .busy(busy), .err(err),
    .dbg_state(dbg_state), .dbg_credit(dbg_credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                  m_send = 0;     // 0 = waiting for a VC, 1 = streaming a packet
  int                  m_cur = 0;
  int                  m_last_alloc = NVC - 1;
  bit                  m_bar = 0;
  int                  m_bar_vc = 0;
  bit                  m_err = 0;
  int                  m_credit[NVC] = '{default: BD};
  logic [VW+DW-1:0]    exp_q[$];

  function automatic bit m_ready();
    return m_send && (m_credit[m_cur] != 0);
  endfunction

  always @(posedge clk) begin : model
    bit acc, found, snd;
    int pick;
    if (rst_) begin
      m_send = 0; m_cur = 0; m_last_alloc = NVC - 1; m_bar = 0; m_bar_vc = 0; m_err = 0;
      for (int v = 0; v < NVC; v++) m_credit[v] = BD;
      exp_q.delete();
    end else begin
      acc = src_valid && m_ready();
      found = 0;
      pick = 0;
      if (!m_send && src_valid) begin
        for (int i = 1; i <= NVC; i++) begin
          int v;
          v = (m_last_alloc + i) % NVC;
          if (!found && irdy[v] && !ilck[v] && m_credit[v] == BD && !(m_bar && m_bar_vc == v)) begin
            found = 1;
            pick = v;
          end
        end
      end
      m_bar = 0;
      for (int v = 0; v < NVC; v++) begin
        snd = acc && (v == m_cur);
        if (snd && !iack[v]) m_credit[v] = m_credit[v] - 1;
        else if (!snd && iack[v]) begin
          if (m_credit[v] == BD) m_err = 1;
          else m_credit[v] = m_credit[v] + 1;
        end
      end
      if (acc) begin
        exp_q.push_back({VW'(m_cur), src_data});
        if (src_last) begin
          m_send = 0;
          m_bar = 1;
          m_bar_vc = m_cur;
        end
      end else if (found) begin
        m_send = 1;
        m_cur = pick;
        m_last_alloc = pick;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin : monitor
    logic [VW+DW-1:0] e;
    chk("ovalid", ovalid, exp_q.size() != 0);
    if (ovalid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("odata", odata, e[DW-1:0]);
      chk("ovch", ovch, e[VW+DW-1:DW]);
    end else begin
      exp_q.delete();
    end
    chk("src_ready", src_ready, m_ready());
    chk("busy", busy, m_send);
    chk("err", err, m_err);
    for (int v = 0; v < NVC; v++)
      chk($sformatf("credit%0d", v), dbg_credit[v*CW +: CW], m_credit[v]);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    src_valid = 0; src_last = 0; iack = '0; irdy = '1; ilck = '0;
    rst_ = 1;
    step();
    rst_ = 0;
  endtask

  function automatic logic [CW-1:0] cred(input int v);
    return dbg_credit[v*CW +: CW];
  endfunction

  // Sends a packet; if ack_vc >= 0, a stall of 3 cycles triggers one credit pulse.
  task automatic send_pkt(input int len, input int ack_vc);
    int  n, stall;
    bit  rdy;
    for (int f = 0; f < len; f++) begin
      src_valid = 1;
      src_data  = $urandom;
      src_last  = (f == len - 1);
      n = 0;
      stall = 0;
      rdy = 0;
      while (!rdy) begin
        rdy = src_ready;
        if (!rdy && busy) stall++; else stall = 0;
        iack = '0;
        if (ack_vc >= 0 && stall == 3) begin
          iack[ack_vc] = 1'b1;
          stall = 0;
        end
        step();
        n++;
        if (!rdy && n > 40) begin
          chk("accept_timeout", 0, 1);
          break;
        end
      end
      iack = '0;
      if (!rdy) break;
    end
    src_valid = 0;
    src_last  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step();
    chk("reset_ovalid", ovalid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    rst_ = 0;

    // 3-flit packet on an idle network
    send_pkt(3, -1);
    chk("p3_ovch", ovch, 0);
    chk("p3_busy_after_tail", busy, 0);
    chk("p3_credit0", cred(0), 1);

    // back-to-back single-flit packets rotate VCs
    do_reset();
    send_pkt(1, -1);
    chk("b2b_first_vc", ovch, 0);
    send_pkt(1, -1);
    chk("b2b_second_vc", ovch, 1);

    // credit stall with trickled credit returns
    do_reset();
    send_pkt(6, 0);
    chk("stall_credit0", cred(0), 0);
    step();

    // send and credit return on the same VC in the same cycle
    do_reset();
    src_valid = 1; src_last = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      src_data = $urandom;
      src_last = (k == 2);
      iack = (k == 2) ? NVC'(1) : '0;
      step();
    end
    src_valid = 0; src_last = 0; iack = '0;
    chk("coincident_credit0", cred(0), 2);
    iack[1] = 1'b1;
    step();
    iack = '0;
    chk("overflow_err", err, 1);
    repeat (3) step();
    chk("overflow_err_sticky", err, 1);

    // all VCs locked, then VC2 released
    do_reset();
    ilck = '1; src_valid = 1; src_last = 1; src_data = $urandom;
    repeat (3) step();
    chk("locked_busy", busy, 0);
    chk("locked_ovalid", ovalid, 0);
    ilck = 4'b1011;
    send_pkt(1, -1);
    chk("unlock_vc2", ovch, 2);
    ilck = '0;

    // reset in the middle of a packet
    do_reset();
    src_valid = 1; src_last = 0;
    step();
    repeat (2) begin
      src_data = $urandom;
      step();
    end
    src_valid = 0;
    rst_ = 1;
    step();
    rst_ = 0;
    chk("midreset_ovalid", ovalid, 0);
    chk("midreset_busy", busy, 0);
    for (int v = 0; v < NVC; v++) chk($sformatf("midreset_credit%0d", v), cred(v), BD);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_      = ($urandom_range(0, 399) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = $urandom;
      src_last  = ($urandom_range(0, 3) == 0);
      for (int v = 0; v < NVC; v++) begin
        iack[v] = (m_credit[v] < BD) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
        irdy[v] = ($urandom_range(0, 4) != 0);
        ilck[v] = ($urandom_range(0, 5) == 0);
      end
      step();
    end
    rst_ = 0; src_valid = 0; iack = '0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
